// File: rtl/l1_cache_pkg.sv
// Shared types, default geometry and the word-merge helper for the L1 data cache.
package l1_cache_pkg;

    localparam int L1_DATA_WIDTH = 32;
    localparam int L1_ADDR_WIDTH = 11;
    localparam int L1_CACHE_SIZE = 128;
    localparam int L1_BLOCK_SIZE = 32;

    localparam int LINE_COUNT = L1_CACHE_SIZE / L1_BLOCK_SIZE;
    localparam int INDEX_W    = $clog2(LINE_COUNT);
    localparam int OFFSET_W   = $clog2(L1_BLOCK_SIZE);
    localparam int TAG_W      = L1_ADDR_WIDTH - INDEX_W - OFFSET_W;
    localparam int BLOCK_BITS = L1_BLOCK_SIZE * L1_DATA_WIDTH;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        FETCH      = 2'd1,
        WRITE_THRU = 2'd2
    } state_t;

    // Replace one word of a block, leaving the rest untouched.
    function automatic logic [BLOCK_BITS-1:0] merge_word(
        input logic [BLOCK_BITS-1:0]    block,
        input logic [OFFSET_W-1:0]      offset,
        input logic [L1_DATA_WIDTH-1:0] word
    );
        logic [BLOCK_BITS-1:0] result;
        result = block;
        result[offset*L1_DATA_WIDTH +: L1_DATA_WIDTH] = word;
        return result;
    endfunction

endpackage

// File: rtl/l1_cache_line_array.sv
// Tag/valid/data storage for the direct-mapped L1; lookup and hit are combinational.
module l1_line_array #(
    parameter int LINES  = 4,
    parameter int IDX_W  = 2,
    parameter int TAG_BW = 4,
    parameter int LINE_W = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IDX_W-1:0]  rd_index,
    input  logic [TAG_BW-1:0] rd_tag,
    output logic              hit,
    output logic [LINE_W-1:0] rd_line,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_index,
    input  logic [TAG_BW-1:0] wr_tag,
    input  logic [LINE_W-1:0] wr_line
);

    logic [LINES-1:0]  valid;
    logic [TAG_BW-1:0] tags  [LINES];
    logic [LINE_W-1:0] lines [LINES];

    // Only valid bits need reset; tag and data are don't-care while invalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            valid <= '0;
        else if (wr_en)
            valid[wr_index] <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tags[wr_index]  <= wr_tag;
            lines[wr_index] <= wr_line;
        end
    end

    assign hit     = valid[rd_index] && (tags[rd_index] == rd_tag);
    assign rd_line = lines[rd_index];

endmodule

// File: rtl/l1_cache.sv
// Direct-mapped, write-through, write-allocate L1 data cache in front of L2.
// Optional L1_STATS_EN adds saturating 16-bit hit/miss counters.
module l1_cache
    import l1_cache_pkg::*;
#(
    parameter int DATA_WIDTH = L1_DATA_WIDTH,
    parameter int ADDR_WIDTH = L1_ADDR_WIDTH,
    parameter int CACHE_SIZE = L1_CACHE_SIZE,
    parameter int BLOCK_SIZE = L1_BLOCK_SIZE
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [ADDR_WIDTH-1:0]            cpu_addr,
    input  logic [DATA_WIDTH-1:0]            cpu_wdata,
    input  logic                             cpu_read,
    input  logic                             cpu_write,
    output logic [DATA_WIDTH-1:0]            cpu_rdata,
    output logic                             cpu_ready,
    output logic                             cpu_busy,
    output logic [ADDR_WIDTH-1:0]            l2_addr,
    output logic [BLOCK_SIZE*DATA_WIDTH-1:0] l2_block_out,
    output logic                             l2_read,
    output logic                             l2_write,
    input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] l2_block_in,
    input  logic                             l2_block_valid,
    input  logic                             l2_ready
`ifdef L1_STATS_EN
    ,
    output logic [15:0]                      stat_hits,
    output logic [15:0]                      stat_misses
`endif
);

    localparam int LINES = CACHE_SIZE / BLOCK_SIZE;
    localparam int IW    = $clog2(LINES);
    localparam int OW    = $clog2(BLOCK_SIZE);
    localparam int TW    = ADDR_WIDTH - IW - OW;
    localparam int BW    = BLOCK_SIZE * DATA_WIDTH;

    state_t                 state;
    logic [ADDR_WIDTH-1:0]  req_addr;
    logic [DATA_WIDTH-1:0]  req_wdata;
    logic                   req_write;

    logic [TW-1:0] cpu_tag, req_tag;
    logic [IW-1:0] cpu_idx, req_idx;
    logic [OW-1:0] cpu_off, req_off;

    logic          accept, hit, fill, write_hit;
    logic [BW-1:0] rd_line;
    logic          wr_en;
    logic [IW-1:0] wr_index;
    logic [TW-1:0] wr_tag;
    logic [BW-1:0] wr_line;

    assign cpu_tag = cpu_addr[ADDR_WIDTH-1 -: TW];
    assign cpu_idx = cpu_addr[OW +: IW];
    assign cpu_off = cpu_addr[OW-1:0];
    assign req_tag = req_addr[ADDR_WIDTH-1 -: TW];
    assign req_idx = req_addr[OW +: IW];
    assign req_off = req_addr[OW-1:0];

    assign accept    = (state == IDLE) && (cpu_read || cpu_write);
    assign write_hit = accept && cpu_write && hit;
    assign fill      = (state == FETCH) && l2_ready && l2_block_valid;

    // One write port serves both hit-merges (from IDLE) and fills (from FETCH).
    always_comb begin
        wr_en    = write_hit || fill;
        wr_index = req_idx;
        wr_tag   = req_tag;
        wr_line  = l2_block_in;
        if (write_hit) begin
            wr_index = cpu_idx;
            wr_tag   = cpu_tag;
            wr_line  = merge_word(rd_line, cpu_off, cpu_wdata);
        end else if (req_write) begin
            wr_line  = merge_word(l2_block_in, req_off, req_wdata);
        end
    end

    l1_line_array #(
        .LINES  (LINES),
        .IDX_W  (IW),
        .TAG_BW (TW),
        .LINE_W (BW)
    ) u_lines (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_index (cpu_idx),
        .rd_tag   (cpu_tag),
        .hit      (hit),
        .rd_line  (rd_line),
        .wr_en    (wr_en),
        .wr_index (wr_index),
        .wr_tag   (wr_tag),
        .wr_line  (wr_line)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            req_addr     <= '0;
            req_wdata    <= '0;
            req_write    <= 1'b0;
            cpu_rdata    <= '0;
            cpu_ready    <= 1'b0;
            l2_addr      <= '0;
            l2_block_out <= '0;
        end else begin
            cpu_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        req_addr  <= cpu_addr;
                        req_wdata <= cpu_wdata;
                        req_write <= cpu_write;
                        l2_addr   <= {cpu_addr[ADDR_WIDTH-1:OW], {OW{1'b0}}};
                        if (cpu_write) begin
                            if (hit) begin
                                l2_block_out <= wr_line;
                                state        <= WRITE_THRU;
                            end else begin
                                state <= FETCH;
                            end
                        end else if (hit) begin
                            cpu_rdata <= rd_line[cpu_off*DATA_WIDTH +: DATA_WIDTH];
                            cpu_ready <= 1'b1;
                        end else begin
                            state <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    // A response without valid data leaves us here; l2_read re-arms once l2_ready drops.
                    if (fill) begin
                        if (req_write) begin
                            l2_block_out <= wr_line;
                            state        <= WRITE_THRU;
                        end else begin
                            cpu_rdata <= l2_block_in[req_off*DATA_WIDTH +: DATA_WIDTH];
                            cpu_ready <= 1'b1;
                            state     <= IDLE;
                        end
                    end
                end
                WRITE_THRU: begin
                    if (l2_ready) begin
                        cpu_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign l2_read  = (state == FETCH) && !l2_ready;
    assign l2_write = (state == WRITE_THRU) && !l2_ready;
    assign cpu_busy = (state != IDLE);

`ifdef L1_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_hits   <= '0;
            stat_misses <= '0;
        end else if (accept) begin
            if (hit) begin
                if (stat_hits != 16'hFFFF)
                    stat_hits <= stat_hits + 16'd1;
            end else if (stat_misses != 16'hFFFF) begin
                stat_misses <= stat_misses + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_l1_cache.sv
// Directed self-checking bench for l1_cache with a 3-cycle L2 responder (word[i] = 0x1000+i).
module tb_l1_cache;

    localparam int DW = 32;
    localparam int AW = 11;
    localparam int BS = 32;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [AW-1:0]    cpu_addr = '0;
    logic [DW-1:0]    cpu_wdata = '0;
    logic             cpu_read = 1'b0;
    logic             cpu_write = 1'b0;
    logic [DW-1:0]    cpu_rdata;
    logic             cpu_ready;
    logic             cpu_busy;
    logic [AW-1:0]    l2_addr;
    logic [BS*DW-1:0] l2_block_out;
    logic             l2_read;
    logic             l2_write;
    logic [BS*DW-1:0] l2_block_in;
    logic             l2_block_valid;
    logic             l2_ready;
`ifdef L1_STATS_EN
    logic [15:0]      stat_hits;
    logic [15:0]      stat_misses;
`endif

    int checks = 0;
    int errors = 0;

    int rd_txn = 0, wr_txn = 0, rd_cycles = 0, ready_pulses = 0, l2_cnt = 0;
    int drop_at = -1;
    logic [AW-1:0]    last_rd_addr = '0, last_wr_addr = '0;
    logic [BS*DW-1:0] last_wr_block = '0;
    logic [BS*DW-1:0] pattern;

    l1_cache dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cpu_addr       (cpu_addr),
        .cpu_wdata      (cpu_wdata),
        .cpu_read       (cpu_read),
        .cpu_write      (cpu_write),
        .cpu_rdata      (cpu_rdata),
        .cpu_ready      (cpu_ready),
        .cpu_busy       (cpu_busy),
        .l2_addr        (l2_addr),
        .l2_block_out   (l2_block_out),
        .l2_read        (l2_read),
        .l2_write       (l2_write),
        .l2_block_in    (l2_block_in),
        .l2_block_valid (l2_block_valid),
        .l2_ready       (l2_ready)
`ifdef L1_STATS_EN
        ,
        .stat_hits      (stat_hits),
        .stat_misses    (stat_misses)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < BS; i++)
            pattern[i*DW +: DW] = 32'h1000 + i;
        l2_block_in = pattern;
    end

    // L2 responder and monitors: sample first, then update the model.
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            l2_ready       = 1'b0;
            l2_block_valid = 1'b0;
            l2_cnt         = 0;
        end else begin
            if (l2_read) begin
                rd_cycles++;
                last_rd_addr = l2_addr;
            end
            if (l2_write) begin
                last_wr_addr  = l2_addr;
                last_wr_block = l2_block_out;
            end
            if (cpu_ready)
                ready_pulses++;
            if (l2_ready) begin
                l2_ready       = 1'b0;
                l2_block_valid = 1'b0;
                l2_cnt         = 0;
            end else if (l2_read || l2_write) begin
                l2_cnt++;
                if (l2_cnt == 3) begin
                    l2_ready = 1'b1;
                    if (l2_read) begin
                        rd_txn++;
                        l2_block_valid = (rd_txn != drop_at);
                    end else begin
                        wr_txn++;
                    end
                end
            end
        end
    end

    task automatic do_req(input logic rd, input logic wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, output int lat);
        @(negedge clk);
        cpu_addr  = a;
        cpu_wdata = d;
        cpu_read  = rd;
        cpu_write = wr;
        @(negedge clk);
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
        lat = 0;
        while (!cpu_ready && lat < 50) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({cpu_ready, cpu_busy, l2_read, l2_write} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 0000", {cpu_ready, cpu_busy, l2_read, l2_write});
        end
        checks++;
        if ({cpu_rdata, l2_addr} !== '0) begin
            errors++;
            $display("FAIL reset_data: rdata %h addr %h expected 0", cpu_rdata, l2_addr);
        end
        checks++;
        if (l2_block_out !== '0) begin
            errors++;
            $display("FAIL reset_block: l2_block_out not zero");
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_cold_read();
        int lat, r0, c0, p0;
        r0 = rd_txn; c0 = rd_cycles; p0 = ready_pulses;
        do_req(1'b1, 1'b0, 11'h045, '0, lat);
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL cold_lat: got %0d expected 3", lat); end
        checks++;
        if (cpu_rdata !== 32'h1005) begin errors++; $display("FAIL cold_rdata: got %h expected 00001005", cpu_rdata); end
        @(negedge clk);
        checks++;
        if (last_rd_addr !== 11'h040) begin errors++; $display("FAIL cold_l2addr: got %h expected 040", last_rd_addr); end
        checks++;
        if (rd_cycles - c0 !== 3) begin errors++; $display("FAIL cold_rd_cycles: got %0d expected 3", rd_cycles - c0); end
        checks++;
        if (rd_txn - r0 !== 1) begin errors++; $display("FAIL cold_rd_txn: got %0d expected 1", rd_txn - r0); end
        checks++;
        if (ready_pulses - p0 !== 1) begin errors++; $display("FAIL cold_ready_pulses: got %0d expected 1", ready_pulses - p0); end
    endtask

    task automatic test_read_hit();
        int lat, c0;
        c0 = rd_cycles;
        do_req(1'b1, 1'b0, 11'h047, '0, lat);
        checks++;
        if (lat !== 0) begin errors++; $display("FAIL hit_lat: got %0d expected 0", lat); end
        checks++;
        if (cpu_rdata !== 32'h1007) begin errors++; $display("FAIL hit_rdata: got %h expected 00001007", cpu_rdata); end
        @(negedge clk);
        checks++;
        if (cpu_rdata !== 32'h1007) begin errors++; $display("FAIL hit_rdata_hold: got %h expected 00001007", cpu_rdata); end
        checks++;
        if (rd_cycles - c0 !== 0) begin errors++; $display("FAIL hit_no_l2_read: got %0d expected 0", rd_cycles - c0); end
    endtask

    task automatic test_write_hit();
        int lat, w0, p0, bad;
        logic [BS*DW-1:0] exp_blk;
        exp_blk = pattern;
        exp_blk[6*DW +: DW] = 32'hDEADBEEF;
        w0 = wr_txn; p0 = ready_pulses;
        do_req(1'b0, 1'b1, 11'h046, 32'hDEADBEEF, lat);
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL wh_lat: got %0d expected 3", lat); end
        @(negedge clk);
        checks++;
        if (wr_txn - w0 !== 1) begin errors++; $display("FAIL wh_wr_txn: got %0d expected 1", wr_txn - w0); end
        checks++;
        if (last_wr_addr !== 11'h040) begin errors++; $display("FAIL wh_l2addr: got %h expected 040", last_wr_addr); end
        checks++;
        if (last_wr_block !== exp_blk) begin
            errors++;
            bad = 0;
            for (int i = BS - 1; i >= 0; i--)
                if (last_wr_block[i*DW +: DW] !== exp_blk[i*DW +: DW]) bad = i;
            $display("FAIL wh_block: word%0d got %h expected %h", bad, last_wr_block[bad*DW +: DW], exp_blk[bad*DW +: DW]);
        end
        checks++;
        if (ready_pulses - p0 !== 1) begin errors++; $display("FAIL wh_ready_pulses: got %0d expected 1", ready_pulses - p0); end
        do_req(1'b1, 1'b0, 11'h046, '0, lat);
        checks++;
        if (lat !== 0 || cpu_rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL wh_readback: lat %0d rdata %h expected 0 deadbeef", lat, cpu_rdata);
        end
    endtask

    task automatic test_evict();
        int lat, r0;
        r0 = rd_txn;
        do_req(1'b1, 1'b0, 11'h0C5, '0, lat);
        @(negedge clk);
        checks++;
        if (lat !== 3 || rd_txn - r0 !== 1) begin
            errors++;
            $display("FAIL evict_miss: lat %0d txn %0d expected 3 1", lat, rd_txn - r0);
        end
        checks++;
        if (last_rd_addr !== 11'h0C0) begin errors++; $display("FAIL evict_l2addr: got %h expected 0c0", last_rd_addr); end
        r0 = rd_txn;
        do_req(1'b1, 1'b0, 11'h045, '0, lat);
        @(negedge clk);
        checks++;
        if (lat !== 3 || rd_txn - r0 !== 1) begin
            errors++;
            $display("FAIL evict_refetch: lat %0d txn %0d expected 3 1", lat, rd_txn - r0);
        end
        checks++;
        if (last_rd_addr !== 11'h040 || cpu_rdata !== 32'h1005) begin
            errors++;
            $display("FAIL evict_refetch_data: addr %h rdata %h expected 040 00001005", last_rd_addr, cpu_rdata);
        end
    endtask

    task automatic test_write_miss();
        int lat, r0, w0, p0;
        logic [BS*DW-1:0] exp_blk;
        exp_blk = pattern;
        exp_blk[3*DW +: DW] = 32'h5A5A5A5A;
        r0 = rd_txn; w0 = wr_txn; p0 = ready_pulses;
        do_req(1'b0, 1'b1, 11'h123, 32'h5A5A5A5A, lat);
        checks++;
        if (lat !== 7) begin errors++; $display("FAIL wm_lat: got %0d expected 7", lat); end
        @(negedge clk);
        checks++;
        if (rd_txn - r0 !== 1 || wr_txn - w0 !== 1) begin
            errors++;
            $display("FAIL wm_txns: rd %0d wr %0d expected 1 1", rd_txn - r0, wr_txn - w0);
        end
        checks++;
        if (last_rd_addr !== 11'h120 || last_wr_addr !== 11'h120) begin
            errors++;
            $display("FAIL wm_l2addr: rd %h wr %h expected 120 120", last_rd_addr, last_wr_addr);
        end
        checks++;
        if (last_wr_block[3*DW +: DW] !== 32'h5A5A5A5A || last_wr_block !== exp_blk) begin
            errors++;
            $display("FAIL wm_block: word3 %h word0 %h expected 5a5a5a5a 00001000",
                     last_wr_block[3*DW +: DW], last_wr_block[DW-1:0]);
        end
        checks++;
        if (ready_pulses - p0 !== 1) begin errors++; $display("FAIL wm_ready_pulses: got %0d expected 1", ready_pulses - p0); end
        do_req(1'b1, 1'b0, 11'h123, '0, lat);
        checks++;
        if (lat !== 0 || cpu_rdata !== 32'h5A5A5A5A) begin
            errors++;
            $display("FAIL wm_readback: lat %0d rdata %h expected 0 5a5a5a5a", lat, cpu_rdata);
        end
    endtask

    task automatic test_write_wins();
        int lat, r0, w0;
        r0 = rd_txn; w0 = wr_txn;
        do_req(1'b1, 1'b1, 11'h044, 32'h11111111, lat);
        @(negedge clk);
        checks++;
        if (lat !== 3 || wr_txn - w0 !== 1 || rd_txn - r0 !== 0) begin
            errors++;
            $display("FAIL write_wins: lat %0d wr %0d rd %0d expected 3 1 0", lat, wr_txn - w0, rd_txn - r0);
        end
        checks++;
        if (last_wr_block[4*DW +: DW] !== 32'h11111111) begin
            errors++;
            $display("FAIL write_wins_word: got %h expected 11111111", last_wr_block[4*DW +: DW]);
        end
    endtask

    task automatic test_busy_drop();
        int lat, r0, p0;
        r0 = rd_txn; p0 = ready_pulses;
        @(negedge clk);
        cpu_addr = 11'h041; cpu_wdata = 32'h22222222; cpu_write = 1'b1;
        @(negedge clk);
        cpu_write = 1'b0;
        cpu_addr = 11'h0E0; cpu_read = 1'b1;
        @(negedge clk);
        cpu_read = 1'b0;
        lat = 0;
        while (!cpu_ready && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        repeat (6) @(negedge clk);
        checks++;
        if (rd_txn - r0 !== 0 || ready_pulses - p0 !== 1 || cpu_busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_drop: rd %0d pulses %0d busy %b expected 0 1 0", rd_txn - r0, ready_pulses - p0, cpu_busy);
        end
    endtask

    task automatic test_invalid_retry();
        int lat, r0, p0;
        r0 = rd_txn; p0 = ready_pulses;
        drop_at = rd_txn + 1;
        do_req(1'b1, 1'b0, 11'h0E0, '0, lat);
        @(negedge clk);
        drop_at = -1;
        checks++;
        if (lat !== 7 || cpu_rdata !== 32'h1000) begin
            errors++;
            $display("FAIL retry: lat %0d rdata %h expected 7 00001000", lat, cpu_rdata);
        end
        checks++;
        if (rd_txn - r0 !== 2 || ready_pulses - p0 !== 1) begin
            errors++;
            $display("FAIL retry_txns: rd %0d pulses %0d expected 2 1", rd_txn - r0, ready_pulses - p0);
        end
    endtask

    task automatic test_reset_mid_fetch();
        int lat, r0;
        @(negedge clk);
        cpu_addr = 11'h0C5; cpu_read = 1'b1;
        @(negedge clk);
        cpu_read = 1'b0;
        #1;
        checks++;
        if (l2_read !== 1'b1) begin errors++; $display("FAIL rst_mid_pre: l2_read got %b expected 1", l2_read); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (l2_read !== 1'b0 || cpu_busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_drop: l2_read %b busy %b expected 0 0", l2_read, cpu_busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        r0 = rd_txn;
        do_req(1'b1, 1'b0, 11'h045, '0, lat);
        @(negedge clk);
        checks++;
        if (lat !== 3 || rd_txn - r0 !== 1 || cpu_rdata !== 32'h1005) begin
            errors++;
            $display("FAIL rst_mid_miss: lat %0d txn %0d rdata %h expected 3 1 00001005", lat, rd_txn - r0, cpu_rdata);
        end
`ifdef L1_STATS_EN
        checks++;
        if (stat_hits !== 16'd0 || stat_misses !== 16'd1) begin
            errors++;
            $display("FAIL stats: hits %0d misses %0d expected 0 1", stat_hits, stat_misses);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_cold_read();
        test_read_hit();
        test_write_hit();
        test_evict();
        test_write_miss();
        test_write_wins();
        test_busy_drop();
        test_invalid_retry();
        test_reset_mid_fetch();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
